// File: rtl/linea_retardo.sv
// Tapped delay line: shifts 2*N-bit two's-complement samples through DEPTH taps,
// with a saturating fill count. Define LINEA_RETARDO_RD_EN to add the indexed read port.
module linea_retardo #(
  parameter  int N     = 25,
  parameter  int DEPTH = 3,
  localparam int W     = 2 * N,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int SW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [W-1:0] in,
  input  logic                shift,
  input  logic                clear,
`ifdef LINEA_RETARDO_RD_EN
  input  logic [SW-1:0]       sel,
  input  logic                rd_en,
  output logic signed [W-1:0] rd_data,
  output logic                rd_valid,
`endif
  output logic [DEPTH*W-1:0]  taps,
  output logic [CW-1:0]       count,
  output logic                primed,
  output logic                shift_ack
);

  logic signed [W-1:0] tap_q [DEPTH];
  logic signed [W-1:0] tap_d [DEPTH];
  logic [CW-1:0]       count_q, count_d;
  logic                primed_q, primed_d;
  logic                ack_q, ack_d;

  // Clear wins over a simultaneous shift; that sample is dropped unacknowledged.
  always_comb begin
    tap_d    = tap_q;
    count_d  = count_q;
    primed_d = primed_q;
    ack_d    = 1'b0;
    if (clear) begin
      for (int j = 0; j < DEPTH; j++) tap_d[j] = '0;
      count_d  = '0;
      primed_d = 1'b0;
    end else if (shift) begin
      tap_d[0] = in;
      for (int j = 1; j < DEPTH; j++) tap_d[j] = tap_q[j-1];
      count_d  = (count_q == CW'(DEPTH)) ? count_q : count_q + CW'(1);
      primed_d = (count_d == CW'(DEPTH));
      ack_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) tap_q[j] <= '0;
      count_q  <= '0;
      primed_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      for (int j = 0; j < DEPTH; j++) tap_q[j] <= tap_d[j];
      count_q  <= count_d;
      primed_q <= primed_d;
      ack_q    <= ack_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_taps
    assign taps[g*W +: W] = tap_q[g];
  end

  assign count     = count_q;
  assign primed    = primed_q;
  assign shift_ack = ack_q;

`ifdef LINEA_RETARDO_RD_EN
  logic signed [W-1:0] rd_data_q, rd_data_d, rd_pick;
  logic                rd_valid_q, rd_valid_d;

  // Indices with no matching tap fall through to zero.
  always_comb begin
    rd_pick    = '0;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      if (sel == SW'(j)) rd_pick = tap_q[j];
    end
    if (rd_en) begin
      rd_data_d  = rd_pick;
      rd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule

// File: doc/linea_retardo.md
LINEA_RETARDO -- requirements
Module: linea_retardo

Interface
REQ-001 Parameter N, default 25, half data width; each sample is 2*N bits, two's complement.
REQ-002 Parameter DEPTH, default 3, number of taps; legal range 2..64.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in  input  2*N  new sample f[k].
REQ-006 shift  input  1  synchronous shift request, sampled on clk; a level, not a clock.
REQ-007 clear  input  1  synchronous flush of all taps.
REQ-008 taps  output  DEPTH*2*N  tap j (f[k-j]) at bits [(j+1)*2*N-1 : j*2*N]; j=0 is newest.
REQ-009 count  output  clog2(DEPTH+1)  number of valid taps, saturating at DEPTH.
REQ-010 primed  output  1  high when count == DEPTH.
REQ-011 shift_ack  output  1  one-cycle pulse for each accepted shift.
REQ-012 sel  input  clog2(DEPTH)  tap index for the read port; present only with LINEA_RETARDO_RD_EN.
REQ-013 rd_en  input  1  read request; present only with LINEA_RETARDO_RD_EN.
REQ-014 rd_data  output  2*N  selected tap value; present only with LINEA_RETARDO_RD_EN.
REQ-015 rd_valid  output  1  read data valid; present only with LINEA_RETARDO_RD_EN.

Function
REQ-016 On a clk edge with shift=1 and clear=0, the block SHALL load tap0<=in and tap j<=tap j-1 for j=1..DEPTH-1, and discard the old tap DEPTH-1.
REQ-017 With shift=0 and clear=0, all taps, count and primed SHALL hold.
REQ-018 taps SHALL be driven directly from registers; in appears on tap0 exactly 1 cycle after the accepting edge.
REQ-019 Every accepted shift SHALL increment count; once count reaches DEPTH it SHALL stay at DEPTH with no wrap.
REQ-020 primed SHALL be registered and equal (count==DEPTH) in the same cycle that count updates.
REQ-021 shift_ack SHALL be high for exactly the cycle after each accepted shift; back-to-back shifts SHALL give continuous ack.
REQ-022 clear=1 SHALL zero all taps, count, primed and shift_ack on the next edge.
REQ-023 clear SHALL have priority over a simultaneous shift; that sample is dropped and not acknowledged.
REQ-024 Data width SHALL be carried unchanged through every tap, with no truncation, rounding or sign change.

Reset
REQ-025 rst_n=0 SHALL immediately force taps=0, count=0, primed=0, shift_ack=0, rd_data=0 and rd_valid=0, independent of clk.
REQ-026 Reset asserted mid-operation SHALL discard all history; the first shift after deassertion SHALL yield count=1.
REQ-027 Reset deassertion SHALL be used only synchronously to clk; a shift in the deassertion cycle is legal.

Configuration
REQ-028 Macro LINEA_RETARDO_RD_EN, when defined, SHALL add sel, rd_en, rd_data and rd_valid.
REQ-029 With the macro defined, rd_en=1 SHALL give rd_data = tap[sel] (pre-shift value in that cycle) and rd_valid=1 one cycle later; otherwise rd_valid=0 and rd_data holds.
REQ-030 With the macro defined, sel >= DEPTH SHALL return rd_data=0 with rd_valid=1.
REQ-031 Without the macro, the read ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 N=25, DEPTH=3, reset, then shift in 5, 7, 9 on consecutive cycles -> taps={9,7,5} (tap0=9), count=3, primed=1 on the cycle after the third ack.
REQ-033 Continue with a 4th shift of -1 (all ones) -> taps={-1,9,7}, count stays 3, tap2 value 5 discarded.
REQ-034 shift=1 and clear=1 in the same cycle with in=42 -> all taps 0, count=0, primed=0, no shift_ack pulse.
REQ-035 Assert rst_n=0 between clock edges after 2 shifts -> outputs zero before the next edge; after release, 1 shift gives count=1.
REQ-036 With LINEA_RETARDO_RD_EN, DEPTH=4, taps={4,3,2,1}: rd_en with sel=2 -> rd_data=2 and rd_valid=1 one cycle later; sel=5 is not encodable, so with DEPTH=3 use sel=3 -> rd_data=0.
REQ-037 Hold shift=0 for 100 cycles after priming -> taps, count and primed unchanged; shift_ack stays 0.
